// File: rtl/tile_scheduler.sv
// Walks the tile-index map in row-major order and hands each tile to the drawer.
// Optional build macro TILE_SCHEDULER_SKIP_EMPTY_EN: index 0 tiles are transparent and never drawn.
module tile_scheduler #(
    parameter int unsigned MAP_COLS   = 20,
    parameter int unsigned MAP_ROWS   = 15,
    parameter int unsigned TILE_SIZE  = 8,
    parameter int unsigned TILE_BYTES = 192,
    parameter int unsigned MAP_AW     = 9,
    parameter int unsigned ROM_AW     = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [MAP_AW-1:0] map_rd_addr,
    input  logic [7:0]        map_rd_data,
    input  logic              drawer_busy,
    output logic              drawer_draw,
    output logic [ROM_AW-1:0] tile_address,
    output logic [7:0]        x_pos,
    output logic [7:0]        y_pos,
    output logic              frame_busy,
    output logic              frame_done
);

    localparam int unsigned COL_W = (MAP_COLS > 1) ? $clog2(MAP_COLS) : 1;
    localparam int unsigned ROW_W = (MAP_ROWS > 1) ? $clog2(MAP_ROWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_DATA,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_ADVANCE
    } state_t;

    state_t            state, state_d;
    logic [COL_W-1:0]  col, col_d;
    logic [ROW_W-1:0]  row, row_d;
    logic [MAP_AW-1:0] map_rd_addr_d;
    logic [ROM_AW-1:0] tile_address_d;
    logic [7:0]        x_pos_d, y_pos_d;
    logic              drawer_draw_d, frame_busy_d, frame_done_d;
    logic              last_col, last_row;

    assign last_col = (col == COL_W'(MAP_COLS - 1));
    assign last_row = (row == ROW_W'(MAP_ROWS - 1));

    // Next-state and next-output logic; the read address is set on entry to S_FETCH
    // so it is already on the bus for the whole fetch cycle.
    always_comb begin
        state_d        = state;
        col_d          = col;
        row_d          = row;
        map_rd_addr_d  = map_rd_addr;
        tile_address_d = tile_address;
        x_pos_d        = x_pos;
        y_pos_d        = y_pos;
        frame_busy_d   = frame_busy;
        drawer_draw_d  = 1'b0;
        frame_done_d   = 1'b0;

        case (state)
            S_IDLE: begin
                // frame_done is high during the first idle cycle; start then is dropped
                if (start && !frame_done) begin
                    col_d         = '0;
                    row_d         = '0;
                    map_rd_addr_d = '0;
                    frame_busy_d  = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT_DATA;
            S_WAIT_DATA: begin
                tile_address_d = ROM_AW'(32'(map_rd_data) * TILE_BYTES);
                x_pos_d        = 8'(32'(col) * TILE_SIZE);
                y_pos_d        = 8'(32'(row) * TILE_SIZE);
`ifdef TILE_SCHEDULER_SKIP_EMPTY_EN
                if (map_rd_data == 8'd0) begin
                    state_d = S_ADVANCE;
                end else begin
                    drawer_draw_d = 1'b1;
                    state_d       = S_ISSUE;
                end
`else
                drawer_draw_d = 1'b1;
                state_d       = S_ISSUE;
`endif
            end
            S_ISSUE:     state_d = S_WAIT_ACK;
            S_WAIT_ACK:  if (drawer_busy) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (!drawer_busy) state_d = S_ADVANCE;
            S_ADVANCE: begin
                if (last_col && last_row) begin
                    frame_done_d = 1'b1;
                    frame_busy_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row + ROW_W'(1);
                    end else begin
                        col_d = col + COL_W'(1);
                    end
                    map_rd_addr_d = MAP_AW'(32'(row_d) * MAP_COLS + 32'(col_d));
                    state_d       = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            col          <= '0;
            row          <= '0;
            map_rd_addr  <= '0;
            tile_address <= '0;
            x_pos        <= '0;
            y_pos        <= '0;
            drawer_draw  <= 1'b0;
            frame_busy   <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_d;
            col          <= col_d;
            row          <= row_d;
            map_rd_addr  <= map_rd_addr_d;
            tile_address <= tile_address_d;
            x_pos        <= x_pos_d;
            y_pos        <= y_pos_d;
            drawer_draw  <= drawer_draw_d;
            frame_busy   <= frame_busy_d;
            frame_done   <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench for tile_scheduler: map RAM and drawer models, per-draw checking in a monitor.
module tb_tile_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  map_rd_addr;
    logic [7:0]  map_rd_data;
    logic        drawer_busy;
    logic        drawer_draw;
    logic [11:0] tile_address;
    logic [7:0]  x_pos;
    logic [7:0]  y_pos;
    logic        frame_busy;
    logic        frame_done;

    tile_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .map_rd_addr  (map_rd_addr),
        .map_rd_data  (map_rd_data),
        .drawer_busy  (drawer_busy),
        .drawer_draw  (drawer_draw),
        .tile_address (tile_address),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .frame_busy   (frame_busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ta;
        int x;
        int y;
    } exp_t;

    exp_t exp_q[$];
    int   cap_ta[$];
    int   cap_x[$];
    int   cap_y[$];
    int   checks   = 0;
    int   failures = 0;
    int   draw_cnt = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;

    logic [7:0] map_mem [0:511];

    // Synchronous-read map RAM: data one cycle after the address.
    always @(posedge clk) map_rd_data <= map_mem[map_rd_addr];

    // Drawer: busy for 4 cycles starting one cycle after each draw.
    always @(posedge clk) begin
        if (drawer_draw) busy_cnt <= 4;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign drawer_busy = (busy_cnt != 0);

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    // Monitor: pop an expectation for every draw pulse.
    always @(negedge clk) begin
        if (drawer_draw) begin
            draw_cnt++;
            cap_ta.push_back(int'(tile_address));
            cap_x.push_back(int'(x_pos));
            cap_y.push_back(int'(y_pos));
            if (exp_q.size() == 0) begin
                chk("unexpected_draw", draw_cnt, -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("draw_tile_address", int'(tile_address), e.ta);
                chk("draw_x_pos", int'(x_pos), e.x);
                chk("draw_y_pos", int'(y_pos), e.y);
            end
        end
        if (frame_done) done_cnt++;
    end

    function automatic void push_frame();
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 20; c++) begin
                int idx;
                idx = int'(map_mem[r * 20 + c]);
`ifdef TILE_SCHEDULER_SKIP_EMPTY_EN
                if (idx == 0) continue;
`endif
                exp_q.push_back('{(idx * 192) % 4096, (c * 8) % 256, (r * 8) % 256});
            end
        end
    endfunction

    function automatic void fill_map1();
        for (int i = 0; i < 512; i++) map_mem[i] = 8'((i % 9) + 1);
        map_mem[0]  = 8'd3;
        map_mem[21] = 8'd1;
        map_mem[22] = 8'd22;
    endfunction

    function automatic void fill_map2();
        for (int i = 0; i < 512; i++) map_mem[i] = 8'd0;
        map_mem[5]   = 8'd2;
        map_mem[299] = 8'd5;
    endfunction

    function automatic void cap_chk(input string nm, input int idx, input int ta, input int x, input int y);
        if (idx >= cap_ta.size()) begin
            chk({nm, "_missing"}, cap_ta.size(), idx + 1);
        end else begin
            if (ta >= 0) chk({nm, "_ta"}, cap_ta[idx], ta);
            chk({nm, "_x"}, cap_x[idx], x);
            chk({nm, "_y"}, cap_y[idx], y);
        end
    endfunction

    function automatic void chk_all_zero(input string nm);
        chk({nm, "_map_rd_addr"}, int'(map_rd_addr), 0);
        chk({nm, "_drawer_draw"}, int'(drawer_draw), 0);
        chk({nm, "_tile_address"}, int'(tile_address), 0);
        chk({nm, "_x_pos"}, int'(x_pos), 0);
        chk({nm, "_y_pos"}, int'(y_pos), 0);
        chk({nm, "_frame_busy"}, int'(frame_busy), 0);
        chk({nm, "_frame_done"}, int'(frame_done), 0);
    endfunction

    // Run until frame_done, optionally pulsing a stray start after mid_draw draws.
    task automatic run_until_done(input int base, input int mid_draw);
        int  cyc;
        bit  pulsed;
        bit  seen;
        cyc = 0;
        pulsed = 0;
        seen = 0;
        while (cyc < 5000 && !seen) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (frame_done) begin
                seen = 1;
            end else if (mid_draw >= 0 && !pulsed && (draw_cnt - base) >= mid_draw) begin
                start = 1'b1;
                pulsed = 1;
            end
        end
        if (!seen) chk("frame_timeout", cyc, -1);
    endtask

    initial begin
        int base;
        int dbase;
        int cyc;
        reset = 1'b1;
        start = 1'b0;
        fill_map1();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");

        // Frame 1: directed indices plus a stray start at tile 50
        push_frame();
        base = draw_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(frame_busy), 1);
        chk("addr_after_start", int'(map_rd_addr), 0);
        run_until_done(base, 50);
        chk("frame1_done_pulse", int'(frame_done), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_on_done_ignored", int'(frame_busy), 0);
        chk("frame1_done_single", int'(frame_done), 0);
        chk("frame1_draws", draw_cnt - base, 300);
        chk("frame1_done_count", done_cnt, 1);
        chk("frame1_queue_empty", exp_q.size(), 0);
        cap_chk("tile0", base + 0, 576, 0, 0);
        cap_chk("tile21", base + 21, 192, 8, 8);
        cap_chk("tile22_wrap", base + 22, 128, 16, 8);
        cap_chk("tile299", base + 299, 576, 152, 112);
        repeat (3) @(negedge clk);

        // Frame 2: mostly empty map
        fill_map2();
        push_frame();
        base = draw_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_until_done(base, -1);
        @(negedge clk);
        chk("frame2_done_count", done_cnt, 2);
        chk("frame2_busy_cleared", int'(frame_busy), 0);
        chk("frame2_queue_empty", exp_q.size(), 0);
`ifdef TILE_SCHEDULER_SKIP_EMPTY_EN
        chk("frame2_draws", draw_cnt - base, 2);
        cap_chk("frame2_first", base, 384, 40, 0);
        cap_chk("frame2_last", base + 1, 960, 152, 112);
`else
        chk("frame2_draws", draw_cnt - base, 300);
        cap_chk("frame2_first", base, 0, 0, 0);
        cap_chk("frame2_tile5", base + 5, 384, 40, 0);
        cap_chk("frame2_last", base + 299, 960, 152, 112);
`endif
        repeat (3) @(negedge clk);

        // Frame 3: reset asserted at tile 100
        fill_map1();
        push_frame();
        base = draw_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 3000 && (draw_cnt - base) < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("frame3_reached_tile100", (draw_cnt - base) >= 100 ? 1 : 0, 1);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        reset = 1'b0;
        exp_q.delete();
        dbase = draw_cnt;
        repeat (40) @(negedge clk);
        chk("no_done_after_reset", done_cnt, 2);
        chk("no_draw_after_reset", draw_cnt - dbase, 0);
        chk("idle_after_reset", int'(frame_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
